// File: rtl/spi_cmd_ctrl.sv
// spi_cmd_ctrl: command layer between the SPI slave byte interface and an
// 8-bit register file. Frames on synchronised chip-select, decodes a command
// byte and an address byte, then streams data bytes in or out.
// Optional frame/error status counters: define SPI_CMD_STATUS_EN.
module spi_cmd_ctrl #(
    parameter int unsigned ADDR_W   = 4,
    parameter logic [7:0]  ACK_BYTE = 8'hA5
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              csn,
    input  logic [7:0]        rx_data,
    input  logic              rx_ready,
    output logic [7:0]        tx_data,
    output logic              wr_strobe,
    output logic [ADDR_W-1:0] wr_addr,
    output logic [7:0]        wr_data,
    output logic [7:0]        ctrl0,
    output logic [7:0]        ctrl1,
    output logic              busy
);

    localparam int unsigned DEPTH     = 2 ** ADDR_W;
    localparam logic [7:0]  CMD_WRITE = 8'h01;
    localparam logic [7:0]  CMD_READ  = 8'h02;
`ifdef SPI_CMD_STATUS_EN
    localparam logic [7:0]  CMD_STATUS = 8'h03;
`endif

    typedef enum logic [2:0] {
        S_IDLE,
        S_CMD,
        S_ADDR,
        S_WDATA,
        S_RDATA,
        S_STAT,
        S_DISCARD
    } state_t;

    state_t            state;
    logic              cs_meta;
    logic              cs_prev;
    logic              armed;
    logic [1:0]        settle;
    logic              cs_s;
    logic              frame_start;
    logic              frame_end;
    logic [ADDR_W-1:0] addr;
    logic              is_read;
    logic [7:0]        regs [DEPTH];
`ifdef SPI_CMD_STATUS_EN
    logic [7:0]        frame_cnt;
    logic [7:0]        err_cnt;
    logic              stat_idx;
`endif

    // busy is the second synchroniser stage stored inverted, so cs_s = ~busy.
    // armed blocks a false frame start when reset is released with csn low:
    // the rest of an interrupted frame is ignored until csn is seen high.
    always_ff @(posedge clk) begin
        if (rst) begin
            cs_meta <= 1'b1;
            busy    <= 1'b0;
            cs_prev <= 1'b1;
            settle  <= 2'b00;
            armed   <= 1'b0;
        end else begin
            cs_meta <= csn;
            busy    <= ~cs_meta;
            cs_prev <= cs_s;
            settle  <= {settle[0], 1'b1};
            if (settle[1] && cs_s) begin
                armed <= 1'b1;
            end
        end
    end

    assign cs_s        = ~busy;
    assign frame_start = armed & cs_prev & ~cs_s;
    assign frame_end   = ~cs_prev & cs_s;
    assign ctrl0       = regs[0];
    assign ctrl1       = regs[1];

    // Command FSM: byte decode first, then frame-end/start overrides state.
    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= S_IDLE;
            tx_data   <= '0;
            wr_strobe <= 1'b0;
            wr_addr   <= '0;
            wr_data   <= '0;
            addr      <= '0;
            is_read   <= 1'b0;
            for (int unsigned i = 0; i < DEPTH; i++) begin
                regs[i] <= '0;
            end
`ifdef SPI_CMD_STATUS_EN
            frame_cnt <= '0;
            err_cnt   <= '0;
            stat_idx  <= 1'b0;
`endif
        end else begin
            wr_strobe <= 1'b0;

            if (rx_ready && state != S_IDLE) begin
                case (state)
                    S_CMD: begin
                        case (rx_data)
                            CMD_WRITE: begin
                                state   <= S_ADDR;
                                is_read <= 1'b0;
                                tx_data <= ACK_BYTE;
                            end
                            CMD_READ: begin
                                state   <= S_ADDR;
                                is_read <= 1'b1;
                                tx_data <= ACK_BYTE;
                            end
`ifdef SPI_CMD_STATUS_EN
                            CMD_STATUS: begin
                                state    <= S_STAT;
                                stat_idx <= 1'b0;
                                tx_data  <= frame_cnt;
                            end
`endif
                            default: begin
                                state   <= S_DISCARD;
                                tx_data <= '0;
`ifdef SPI_CMD_STATUS_EN
                                if (err_cnt != 8'hFF) begin
                                    err_cnt <= err_cnt + 8'd1;
                                end
`endif
                            end
                        endcase
                    end
                    S_ADDR: begin
                        addr <= rx_data[ADDR_W-1:0];
                        if (is_read) begin
                            state   <= S_RDATA;
                            tx_data <= regs[rx_data[ADDR_W-1:0]];
                        end else begin
                            state <= S_WDATA;
                        end
                    end
                    S_WDATA: begin
                        regs[addr] <= rx_data;
                        wr_strobe  <= 1'b1;
                        wr_addr    <= addr;
                        wr_data    <= rx_data;
                        addr       <= addr + ADDR_W'(1);
                    end
                    S_RDATA: begin
                        addr    <= addr + ADDR_W'(1);
                        tx_data <= regs[addr + ADDR_W'(1)];
                    end
                    S_STAT: begin
`ifdef SPI_CMD_STATUS_EN
                        if (!stat_idx) begin
                            tx_data  <= err_cnt;
                            stat_idx <= 1'b1;
                        end else begin
                            tx_data <= '0;
                        end
`else
                        tx_data <= '0;
`endif
                    end
                    default: ;
                endcase
            end

            if (frame_end && state != S_IDLE) begin
                state   <= S_IDLE;
                tx_data <= '0;
`ifdef SPI_CMD_STATUS_EN
                if (frame_cnt != 8'hFF) begin
                    frame_cnt <= frame_cnt + 8'd1;
                end
                if ((state == S_CMD || state == S_ADDR) && !rx_ready && err_cnt != 8'hFF) begin
                    err_cnt <= err_cnt + 8'd1;
                end
`endif
            end else if (frame_start) begin
`ifdef SPI_CMD_STATUS_EN
                if (state != S_IDLE && frame_cnt != 8'hFF) begin
                    frame_cnt <= frame_cnt + 8'd1;
                end
`endif
                state   <= S_CMD;
                tx_data <= '0;
            end else if (state == S_IDLE) begin
                tx_data <= '0;
            end
        end
    end

endmodule

// File: tb/tb_spi_cmd_ctrl.sv
// Testbench for spi_cmd_ctrl: directed scenarios plus random frames, all
// outputs checked every cycle against a byte-index reference model.
module tb_spi_cmd_ctrl;

    localparam int unsigned ADDR_W = 4;
    localparam int unsigned DEPTH  = 16;
    localparam logic [7:0]  ACK    = 8'hA5;
`ifdef SPI_CMD_STATUS_EN
    localparam bit STATUS_EN = 1'b1;
`else
    localparam bit STATUS_EN = 1'b0;
`endif

    logic              clk;
    logic              rst;
    logic              csn;
    logic [7:0]        rx_data;
    logic              rx_ready;
    logic [7:0]        tx_data;
    logic              wr_strobe;
    logic [ADDR_W-1:0] wr_addr;
    logic [7:0]        wr_data;
    logic [7:0]        ctrl0;
    logic [7:0]        ctrl1;
    logic              busy;

    int checks = 0;
    int errors = 0;
    int strobes_seen = 0;

    spi_cmd_ctrl #(.ADDR_W(ADDR_W), .ACK_BYTE(ACK)) dut (
        .clk(clk), .rst(rst), .csn(csn), .rx_data(rx_data), .rx_ready(rx_ready),
        .tx_data(tx_data), .wr_strobe(wr_strobe), .wr_addr(wr_addr), .wr_data(wr_data),
        .ctrl0(ctrl0), .ctrl1(ctrl1), .busy(busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // ---------------- reference model ----------------
    // Frame view: csn is seen by the controller two clocks late; after reset
    // the controller must first see csn high before a new frame can open.
    bit          m_live = 1'b0;
    int          m_n;
    bit          m_raw1, m_vis, m_vis_prev, m_armed, m_active;
    int          m_idx;
    logic [7:0]  m_cmd;
    int          m_addr;
    logic [7:0]  m_regs [DEPTH];
    logic [7:0]  m_tx, m_wdata;
    logic [3:0]  m_waddr;
    bit          m_strobe;
    int          m_frames, m_errs;

    function automatic int sat(input int x);
        return (x < 255) ? x + 1 : x;
    endfunction

    function automatic bit is_rw(input logic [7:0] c);
        return (c == 8'h01) || (c == 8'h02);
    endfunction

    task automatic take_byte(input logic [7:0] b);
        if (m_idx == 0) begin
            m_cmd = b;
            if (is_rw(b)) m_tx = ACK;
            else if (STATUS_EN && b == 8'h03) m_tx = 8'(m_frames);
            else begin
                m_tx   = 8'h00;
                m_errs = sat(m_errs);
            end
        end else if (is_rw(m_cmd)) begin
            if (m_idx == 1) begin
                m_addr = int'(b) % DEPTH;
                if (m_cmd == 8'h02) m_tx = m_regs[m_addr];
            end else if (m_cmd == 8'h01) begin
                m_regs[m_addr] = b;
                m_strobe = 1'b1;
                m_waddr  = 4'(m_addr);
                m_wdata  = b;
                m_addr   = (m_addr + 1) % DEPTH;
            end else begin
                m_addr = (m_addr + 1) % DEPTH;
                m_tx   = m_regs[m_addr];
            end
        end else if (STATUS_EN && m_cmd == 8'h03) begin
            m_tx = (m_idx == 1) ? 8'(m_errs) : 8'h00;
        end
        if (m_idx < 3) m_idx++;
    endtask

    always @(posedge clk) begin
        if (rst) begin
            m_live = 1'b1;
            m_n = 0; m_raw1 = 1'b1; m_vis = 1'b1; m_vis_prev = 1'b1; m_armed = 1'b0;
            m_active = 1'b0; m_idx = 0; m_cmd = 8'h00; m_addr = 0;
            for (int i = 0; i < DEPTH; i++) m_regs[i] = 8'h00;
            m_tx = 8'h00; m_wdata = 8'h00; m_waddr = 4'h0; m_strobe = 1'b0;
            m_frames = 0; m_errs = 0;
        end else if (m_live) begin
            bit start, stop;
            int idx0;
            start = m_armed && m_vis_prev && !m_vis;
            stop  = !m_vis_prev && m_vis;
            m_strobe = 1'b0;
            idx0 = m_idx;
            if (m_active && rx_ready) take_byte(rx_data);
            if (m_active && stop) begin
                m_frames = sat(m_frames);
                if (!rx_ready && (idx0 == 0 || (idx0 == 1 && is_rw(m_cmd)))) m_errs = sat(m_errs);
                m_active = 1'b0;
                m_tx = 8'h00;
            end else if (start) begin
                if (m_active) m_frames = sat(m_frames);
                m_active = 1'b1;
                m_idx = 0;
                m_tx = 8'h00;
            end else if (!m_active) begin
                m_tx = 8'h00;
            end
            if (m_n >= 2 && m_vis) m_armed = 1'b1;
            m_vis_prev = m_vis;
            if (m_n < 3) m_n++;
            m_vis  = (m_n >= 2) ? m_raw1 : 1'b1;
            m_raw1 = csn;
        end
    end

    // Every-cycle comparison against the model.
    always @(negedge clk) begin
        if (m_live) begin
            chk("tx_data", tx_data, m_tx);
            chk("wr_strobe", wr_strobe, m_strobe);
            chk("wr_addr", wr_addr, m_waddr);
            chk("wr_data", wr_data, m_wdata);
            chk("ctrl0", ctrl0, m_regs[0]);
            chk("ctrl1", ctrl1, m_regs[1]);
            chk("busy", busy, !m_vis);
            if (wr_strobe) strobes_seen++;
        end
    end

    // ---------------- stimulus ----------------
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) tick();
    endtask

    task automatic tx_byte(input logic [7:0] b);
        rx_data  = b;
        rx_ready = 1'b1;
        tick();
        rx_ready = 1'b0;
    endtask

    task automatic frame_begin();
        csn = 1'b0;
        idle(4);
    endtask

    task automatic frame_end();
        idle(2);
        csn = 1'b1;
        idle(4);
    endtask

    task automatic do_reset();
        rst = 1'b1;
        idle(2);
        rst = 1'b0;
        idle(5);
    endtask

    task automatic rand_frame();
        logic [7:0] c, b;
        int nb;
        bit coinc, do_rst;
        case ($urandom_range(0, 4))
            0, 1:    c = 8'h01;
            2:       c = 8'h02;
            3:       c = 8'h03;
            default: c = 8'($urandom);
        endcase
        nb     = $urandom_range(0, 6);
        coinc  = (nb > 0) && ($urandom_range(0, 3) == 0);
        do_rst = ($urandom_range(0, 24) == 0);
        frame_begin();
        for (int i = 0; i < nb; i++) begin
            b = (i == 0) ? c : 8'($urandom);
            if (i == 1 && $urandom_range(0, 1) == 1) b = 8'($urandom_range(0, 3)) | 8'($urandom_range(0, 1) << 4);
            if (coinc && i == nb - 1) begin
                csn = 1'b1;
                tick();
                tick();
                tx_byte(b);
                idle(4);
                return;
            end
            tx_byte(b);
            idle($urandom_range(0, 3));
            if (do_rst && i == 1) begin
                rst = 1'b1;
                tick();
                rst = 1'b0;
            end
        end
        frame_end();
        if ($urandom_range(0, 5) == 0) begin
            tx_byte(8'($urandom));
            idle(2);
        end
    endtask

    initial begin
        rst = 1'b1; csn = 1'b1; rx_ready = 1'b0; rx_data = 8'h00;
        idle(3);
        chk("rst_tx", tx_data, 8'h00);
        chk("rst_busy", busy, 1'b0);
        chk("rst_strobe", wr_strobe, 1'b0);
        chk("rst_waddr", wr_addr, 4'h0);
        chk("rst_ctrl0", ctrl0, 8'h00);
        rst = 1'b0;
        idle(5);

        // Write burst 01,00,3C,81
        strobes_seen = 0;
        frame_begin();
        chk("busy_in_frame", busy, 1'b1);
        tx_byte(8'h01); chk("ack_byte", tx_data, 8'hA5); idle(2);
        tx_byte(8'h00); idle(2);
        tx_byte(8'h3C); idle(2);
        tx_byte(8'h81); idle(2);
        frame_end();
        chk("wburst_ctrl0", ctrl0, 8'h3C);
        chk("wburst_ctrl1", ctrl1, 8'h81);
        chk("wburst_strobes", strobes_seen, 2);
        chk("model_reg0", m_regs[0], 8'h3C);

        // Read burst: preload reg5/reg6, then read them back
        frame_begin();
        tx_byte(8'h01); tx_byte(8'h05); tx_byte(8'h11); tx_byte(8'h22);
        frame_end();
        strobes_seen = 0;
        frame_begin();
        tx_byte(8'h02); idle(2);
        tx_byte(8'h05); chk("rd_byte2", tx_data, 8'h11); idle(2);
        tx_byte(8'hE7); chk("rd_byte3", tx_data, 8'h22); idle(2);
        tx_byte(8'h19); idle(1);
        frame_end();
        chk("rd_no_strobe", strobes_seen, 0);

        // Address wrap and upper address bits ignored
        frame_begin();
        tx_byte(8'h01); tx_byte(8'h0F); tx_byte(8'hAA); idle(1); tx_byte(8'hBB);
        frame_end();
        chk("wrap_ctrl0", ctrl0, 8'hBB);
        chk("model_reg15", m_regs[15], 8'hAA);
        frame_begin();
        tx_byte(8'h01); tx_byte(8'hF3); tx_byte(8'h5A);
        frame_end();
        frame_begin();
        tx_byte(8'h02); idle(1); tx_byte(8'h03);
        chk("addr_mask_rd", tx_data, 8'h5A);
        frame_end();

        // Invalid command from a fresh reset, then a status frame
        do_reset();
        strobes_seen = 0;
        frame_begin();
        tx_byte(8'h7E); chk("inv_tx0", tx_data, 8'h00); idle(1);
        tx_byte(8'h00); chk("inv_tx1", tx_data, 8'h00); idle(1);
        tx_byte(8'h55); chk("inv_tx2", tx_data, 8'h00);
        frame_end();
        chk("inv_no_strobe", strobes_seen, 0);
        frame_begin();
        tx_byte(8'h03); chk("stat_frames", tx_data, STATUS_EN ? 8'h01 : 8'h00); idle(1);
        tx_byte(8'h9C); chk("stat_errs", tx_data, STATUS_EN ? 8'h01 : 8'h00); idle(1);
        tx_byte(8'h9C); chk("stat_tail", tx_data, 8'h00);
        frame_end();

        // Data byte coincident with frame end, then a stray byte with csn high
        frame_begin();
        tx_byte(8'h01); tx_byte(8'h00); tx_byte(8'h66); idle(1);
        csn = 1'b1;
        tick(); tick();
        tx_byte(8'h99);
        chk("coinc_ctrl1", ctrl1, 8'h99);
        chk("coinc_tx", tx_data, 8'h00);
        chk("coinc_busy", busy, 1'b0);
        idle(3);
        strobes_seen = 0;
        tx_byte(8'h44); idle(2);
        chk("idle_rx_ignored", strobes_seen, 0);
        chk("idle_ctrl1", ctrl1, 8'h99);

        // Reset in the middle of a write frame
        frame_begin();
        tx_byte(8'h01); tx_byte(8'h00); tx_byte(8'h77); idle(1);
        chk("pre_rst_ctrl0", ctrl0, 8'h77);
        rst = 1'b1;
        tick();
        rst = 1'b0;
        chk("midrst_ctrl0", ctrl0, 8'h00);
        chk("midrst_tx", tx_data, 8'h00);
        strobes_seen = 0;
        idle(3);
        tx_byte(8'h12); idle(1); tx_byte(8'h34); idle(1);
        chk("midrst_no_strobe", strobes_seen, 0);
        chk("midrst_ctrl1", ctrl1, 8'h00);
        frame_end();

        // Random frames
        for (int f = 0; f < 250; f++) rand_frame();
        idle(4);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
